// File: rtl/hpdl_scan_controller.sv
// hpdl_scan_controller
// Scans the 16-slot character memory through its registered read port and
// refreshes four HPDL1414 displays, one character per prescaler tick.
// Also produces the caret blink phase that the memory uses to overlay the caret.
//
// Handshake/timing contract with the character memory:
//   o_mem_read_enable is a single-cycle pulse with o_mem_read_address = slot;
//   i_mem_read_data must be valid in the following cycle, where it is sampled.
// Display write cycle: data/addr settle (SETUP_CYC), one o_hpdl_wr_n bit low
// (WR_CYC), then data/addr held (HOLD_CYC) before the next slot may start.

module hpdl_scan_controller #(
    parameter int CLK_DIV      = 64,
    parameter int SETUP_CYC    = 2,
    parameter int WR_CYC       = 4,
    parameter int HOLD_CYC     = 1,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    output logic       o_mem_read_enable,
    output logic [3:0] o_mem_read_address,
    input  logic [7:0] i_mem_read_data,
    output logic       o_caret_strobe,
    output logic [6:0] o_hpdl_data,
    output logic [1:0] o_hpdl_addr,
    output logic [3:0] o_hpdl_wr_n,
    output logic       o_frame_done
);

    // Counter widths sized from the parameters.
    localparam int PW     = $clog2(CLK_DIV);
    localparam int PH_MAX = (SETUP_CYC > WR_CYC)
                          ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                          : ((WR_CYC > HOLD_CYC) ? WR_CYC : HOLD_CYC);
    localparam int PHW    = $clog2(PH_MAX + 1);
    localparam int FW     = $clog2(BLINK_FRAMES + 1);

    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PHW-1:0] SETUP_LAST = PHW'(SETUP_CYC - 1);
    localparam logic [PHW-1:0] WR_LAST    = PHW'(WR_CYC - 1);
    localparam logic [PHW-1:0] HOLD_LAST  = PHW'(HOLD_CYC - 1);
    localparam logic [FW-1:0]  BLINK_LAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_READ      = 3'd2,
        S_LATCH     = 3'd3,
        S_SETUP     = 3'd4,
        S_STROBE    = 3'd5,
        S_HOLD      = 3'd6
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [PW-1:0]  r_presc;
    logic           w_tick;
    logic [PHW-1:0] r_ph_cnt;
    logic           w_ph_clr;
    logic [3:0]     r_idx;
    logic [3:0]     w_idx_nxt;
    logic           w_latch;
    logic           w_frame_wrap;
    logic [3:0]     w_wr_n_nxt;
    logic [3:0]     r_wr_n;
    logic [6:0]     r_data;
    logic [1:0]     r_addr;
    logic           r_frame_done;
    logic [FW-1:0]  r_frame_cnt;
    logic           r_caret;

    // Map anything outside the HPDL1414 charset (0x20..0x5F) to a blank.
    function automatic logic [6:0] f_filter(input logic [7:0] c);
        if ((c >= 8'h20) && (c <= 8'h5F)) begin
            return c[6:0];
        end
        return 7'h20;
    endfunction

    // Free-running slot prescaler; held at zero while scanning is disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
        end else if (!i_enable) begin
            r_presc <= '0;
        end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_tick = i_enable && (r_presc == PRESC_LAST);

    // FSM state register plus slot index and phase counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= 4'd0;
            r_ph_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_ph_cnt <= w_ph_clr ? '0 : (r_ph_cnt + PHW'(1));
        end
    end

    // Next-state logic; enable is only honoured at slot boundaries so a
    // started write cycle always runs to the end of HOLD.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_ph_clr     = 1'b1;
        w_latch      = 1'b0;
        w_frame_wrap = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_state_nxt = S_WAIT_TICK;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_WAIT_TICK: begin
                if (!i_enable) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = 4'd0;
                end else if (w_tick) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_latch     = 1'b1;
                w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                if (r_ph_cnt == SETUP_LAST) begin
                    w_state_nxt = S_STROBE;
                end else begin
                    w_ph_clr = 1'b0;
                end
            end
            S_STROBE: begin
                if (r_ph_cnt == WR_LAST) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_ph_clr = 1'b0;
                end
            end
            S_HOLD: begin
                if (r_ph_cnt == HOLD_LAST) begin
                    w_frame_wrap = (r_idx == 4'd15);
                    if (i_enable) begin
                        w_state_nxt = S_WAIT_TICK;
                        w_idx_nxt   = r_idx + 4'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = 4'd0;
                    end
                end else begin
                    w_ph_clr = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 4'd0;
            end
        endcase
    end

    // Write strobe decode for the coming cycle: exactly one display while
    // in STROBE, all high otherwise.
    always_comb begin
        w_wr_n_nxt = 4'b1111;
        if (w_state_nxt == S_STROBE) begin
            w_wr_n_nxt = ~(4'b0001 << w_idx_nxt[3:2]);
        end
    end

    // Registered write strobes so the HPDL WR lines never glitch; async reset
    // releases any active strobe immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_n <= 4'b1111;
        end else begin
            r_wr_n <= w_wr_n_nxt;
        end
    end

    // Capture filtered character and digit address; only updated in LATCH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= 7'h20;
            r_addr <= 2'd0;
        end else if (w_latch) begin
            r_data <= f_filter(i_mem_read_data);
            r_addr <= ~r_idx[1:0];
        end
    end

    // Frame-done pulse and caret blink phase, advanced once per completed frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
            r_caret      <= 1'b1;
        end else begin
            r_frame_done <= w_frame_wrap;
            if (w_frame_wrap) begin
                if (r_frame_cnt == BLINK_LAST) begin
                    r_frame_cnt <= '0;
                    r_caret     <= ~r_caret;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FW'(1);
                end
            end
        end
    end

    assign o_mem_read_enable  = (r_state == S_READ);
    assign o_mem_read_address = r_idx;
    assign o_caret_strobe     = r_caret;
    assign o_hpdl_data        = r_data;
    assign o_hpdl_addr        = r_addr;
    assign o_hpdl_wr_n        = r_wr_n;
    assign o_frame_done       = r_frame_done;

endmodule

// File: tb/tb_hpdl_scan_controller.sv
// Directed testbench for hpdl_scan_controller (small CLK_DIV / BLINK_FRAMES).
module tb_hpdl_scan_controller;

  localparam int CLK_DIV      = 16;
  localparam int SETUP_CYC    = 2;
  localparam int WR_CYC       = 4;
  localparam int HOLD_CYC     = 1;
  localparam int BLINK_FRAMES = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mem_re;
  logic [3:0] mem_ra;
  logic [7:0] mem_rd;
  logic       caret;
  logic [6:0] hdata;
  logic [1:0] haddr;
  logic [3:0] wr_n;
  logic       fdone;

  hpdl_scan_controller #(
    .CLK_DIV(CLK_DIV), .SETUP_CYC(SETUP_CYC), .WR_CYC(WR_CYC),
    .HOLD_CYC(HOLD_CYC), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .o_mem_read_enable(mem_re), .o_mem_read_address(mem_ra),
    .i_mem_read_data(mem_rd), .o_caret_strobe(caret),
    .o_hpdl_data(hdata), .o_hpdl_addr(haddr), .o_hpdl_wr_n(wr_n),
    .o_frame_done(fdone)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // registered-read memory model
  logic [7:0] mem [16];
  always @(posedge clk) if (mem_re) mem_rd <= mem[mem_ra];

  // write-cycle monitor
  typedef struct {
    logic [1:0]  disp;
    logic [1:0]  addr;
    logic [6:0]  data;
    int unsigned t_fall;
    int unsigned width;
    logic        stable;
  } wr_ev_t;

  wr_ev_t      wr_q[$];
  logic [3:0]  rd_q[$];
  int unsigned fd_q[$];
  logic        strobe_q[$];
  wr_ev_t      cur;
  logic        in_pulse = 1'b0;
  int          onehot_bad = 0;

  int checks = 0;
  int errors = 0;

  function automatic logic [1:0] disp_of(input logic [3:0] w);
    case (w)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always @(negedge clk) begin
    if (wr_n != 4'b1111) begin
      if ($countones(~wr_n) != 1) onehot_bad++;
      if (!in_pulse) begin
        in_pulse   = 1'b1;
        cur.disp   = disp_of(wr_n);
        cur.addr   = haddr;
        cur.data   = hdata;
        cur.t_fall = cyc;
        cur.width  = 0;
        cur.stable = 1'b1;
      end
      cur.width++;
      if (haddr != cur.addr || hdata != cur.data) cur.stable = 1'b0;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      wr_q.push_back(cur);
    end
    if (mem_re) rd_q.push_back(mem_ra);
    if (fdone) begin
      fd_q.push_back(cyc);
      strobe_q.push_back(caret);
    end
  end

  // driver tasks
  task automatic clear_logs();
    wr_q.delete(); rd_q.delete(); fd_q.delete(); strobe_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic load_hello();
    string s;
    s = "HELLO WORLD 1234";
    for (int i = 0; i < 16; i++) mem[i] = s[i];
  endtask

  task automatic wait_wr(input int n, input int budget, input string tag, output bit ok);
    int b;
    b = 0;
    while (wr_q.size() < n && b < budget) begin @(negedge clk); b++; end
    ok = (wr_q.size() >= n);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: timeout, got %0d write pulses, required %0d", tag, wr_q.size(), n);
    end
  endtask

  task automatic wait_fd(input int n, input int budget, input string tag, output bit ok);
    int b;
    b = 0;
    while (fd_q.size() < n && b < budget) begin @(negedge clk); b++; end
    ok = (fd_q.size() >= n);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: timeout, got %0d frame_done pulses, required %0d", tag, fd_q.size(), n);
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (mem_re !== 1'b0)     begin errors++; $display("FAIL reset_re: got %b required 0", mem_re); end
    checks++; if (mem_ra !== 4'd0)     begin errors++; $display("FAIL reset_ra: got %h required 0", mem_ra); end
    checks++; if (caret !== 1'b1)      begin errors++; $display("FAIL reset_caret: got %b required 1", caret); end
    checks++; if (hdata !== 7'h20)     begin errors++; $display("FAIL reset_data: got %h required 20", hdata); end
    checks++; if (haddr !== 2'd0)      begin errors++; $display("FAIL reset_addr: got %h required 0", haddr); end
    checks++; if (wr_n !== 4'b1111)    begin errors++; $display("FAIL reset_wr_n: got %b required 1111", wr_n); end
    checks++; if (fdone !== 1'b0)      begin errors++; $display("FAIL reset_fdone: got %b required 0", fdone); end
    rst_n = 1'b1;
    clear_logs();
    repeat (1000) @(negedge clk);
    checks++; if (rd_q.size() != 0)    begin errors++; $display("FAIL idle_reads: got %0d required 0", rd_q.size()); end
    checks++; if (wr_q.size() != 0)    begin errors++; $display("FAIL idle_writes: got %0d required 0", wr_q.size()); end
  endtask

  task automatic test_full_frame();
    string s;
    int unsigned t_en;
    bit ok;
    s = "HELLO WORLD 1234";
    do_reset();
    load_hello();
    @(negedge clk);
    en   = 1'b1;
    t_en = cyc;
    wait_wr(16, 400, "frame_pulses", ok);
    if (!ok) begin en = 1'b0; return; end
    wait_fd(1, 50, "frame_done", ok);
    en = 1'b0;
    if (!ok) return;
    checks++;
    if (wr_q[0].t_fall - t_en != CLK_DIV + 2 + SETUP_CYC) begin
      errors++; $display("FAIL first_wr_latency: got %0d required %0d", wr_q[0].t_fall - t_en, CLK_DIV + 2 + SETUP_CYC);
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (wr_q[i].disp !== 2'(i / 4)) begin errors++; $display("FAIL frame_disp[%0d]: got %0d required %0d", i, wr_q[i].disp, i / 4); end
      checks++; if (wr_q[i].addr !== 2'(3 - (i % 4))) begin errors++; $display("FAIL frame_addr[%0d]: got %0d required %0d", i, wr_q[i].addr, 3 - (i % 4)); end
      checks++; if (wr_q[i].data !== s[i][6:0]) begin errors++; $display("FAIL frame_data[%0d]: got %h required %h", i, wr_q[i].data, s[i][6:0]); end
      checks++; if (wr_q[i].width != WR_CYC) begin errors++; $display("FAIL frame_width[%0d]: got %0d required %0d", i, wr_q[i].width, WR_CYC); end
      checks++; if (wr_q[i].stable !== 1'b1) begin errors++; $display("FAIL frame_stable[%0d]: data/addr moved during WR", i); end
      checks++; if (rd_q[i] !== 4'(i)) begin errors++; $display("FAIL frame_read_addr[%0d]: got %0d required %0d", i, rd_q[i], i); end
      if (i > 0) begin
        checks++;
        if (wr_q[i].t_fall - wr_q[i-1].t_fall != CLK_DIV) begin
          errors++; $display("FAIL frame_spacing[%0d]: got %0d required %0d", i, wr_q[i].t_fall - wr_q[i-1].t_fall, CLK_DIV);
        end
      end
    end
    checks++;
    if (fd_q[0] - wr_q[15].t_fall != WR_CYC + HOLD_CYC) begin
      errors++; $display("FAIL frame_done_pos: got %0d required %0d", fd_q[0] - wr_q[15].t_fall, WR_CYC + HOLD_CYC);
    end
    repeat (40) @(negedge clk);
    checks++; if (fd_q.size() != 1) begin errors++; $display("FAIL frame_done_count: got %0d required 1", fd_q.size()); end
  endtask

  task automatic test_filter();
    logic [7:0] in_v [8];
    logic [6:0] exp_v [8];
    bit ok;
    in_v  = '{8'h1F, 8'h20, 8'h5F, 8'h60, 8'h00, 8'h7A, 8'h41, 8'hC1};
    exp_v = '{7'h20, 7'h20, 7'h5F, 7'h20, 7'h20, 7'h20, 7'h41, 7'h20};
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = (i < 8) ? in_v[i] : 8'h30;
    @(negedge clk);
    en = 1'b1;
    wait_wr(8, 300, "filter_pulses", ok);
    en = 1'b0;
    if (!ok) return;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_q[i].data !== exp_v[i]) begin
        errors++; $display("FAIL filter[%0d] in=%h: got %h required %h", i, in_v[i], wr_q[i].data, exp_v[i]);
      end
    end
    repeat (60) @(negedge clk);
  endtask

  task automatic test_blink();
    bit ok;
    logic exp_s [4];
    exp_s = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    load_hello();
    @(negedge clk);
    en = 1'b1;
    wait_fd(4, 5 * 16 * CLK_DIV, "blink_frames", ok);
    en = 1'b0;
    if (!ok) return;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (strobe_q[i] !== exp_s[i]) begin errors++; $display("FAIL blink[%0d]: got %b required %b", i, strobe_q[i], exp_s[i]); end
      if (i > 0) begin
        checks++;
        if (fd_q[i] - fd_q[i-1] != 16 * CLK_DIV) begin
          errors++; $display("FAIL frame_period[%0d]: got %0d required %0d", i, fd_q[i] - fd_q[i-1], 16 * CLK_DIV);
        end
      end
    end
    repeat (60) @(negedge clk);
  endtask

  task automatic test_disable_mid_strobe();
    int b;
    bit ok;
    do_reset();
    load_hello();
    @(negedge clk);
    en = 1'b1;
    b = 0;
    while (!(wr_n == 4'b1011 && haddr == 2'd2) && b < 400) begin @(negedge clk); b++; end
    checks++;
    if (!(wr_n == 4'b1011 && haddr == 2'd2)) begin
      errors++; $display("FAIL dis_find_slot9: wr_n=%b addr=%0d, slot 9 strobe not seen", wr_n, haddr);
      en = 1'b0; return;
    end
    en = 1'b0;
    wait_wr(10, 40, "dis_pulse_end", ok);
    if (!ok) return;
    checks++; if (wr_q[9].width != WR_CYC) begin errors++; $display("FAIL dis_width: got %0d required %0d", wr_q[9].width, WR_CYC); end
    checks++; if (wr_q[9].disp !== 2'd2)   begin errors++; $display("FAIL dis_disp: got %0d required 2", wr_q[9].disp); end
    repeat (200) @(negedge clk);
    checks++; if (wr_q.size() != 10) begin errors++; $display("FAIL dis_quiet_wr: got %0d required 10", wr_q.size()); end
    checks++; if (rd_q.size() != 10) begin errors++; $display("FAIL dis_quiet_rd: got %0d required 10", rd_q.size()); end
    checks++; if (fd_q.size() != 0)  begin errors++; $display("FAIL dis_no_fdone: got %0d required 0", fd_q.size()); end
    rd_q.delete();
    en = 1'b1;
    b = 0;
    while (rd_q.size() == 0 && b < 100) begin @(negedge clk); b++; end
    en = 1'b0;
    checks++;
    if (rd_q.size() == 0) begin errors++; $display("FAIL dis_reenable: no read after re-enable"); end
    else if (rd_q[0] !== 4'd0) begin errors++; $display("FAIL dis_restart_addr: got %0d required 0", rd_q[0]); end
    repeat (60) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int b;
    bit ok;
    do_reset();
    load_hello();
    @(negedge clk);
    en = 1'b1;
    wait_fd(2, 3 * 16 * CLK_DIV, "arst_frames", ok);
    if (!ok) begin en = 1'b0; return; end
    checks++; if (caret !== 1'b0) begin errors++; $display("FAIL arst_pre_caret: got %b required 0", caret); end
    b = 0;
    while (wr_n == 4'b1111 && b < 100) begin @(negedge clk); b++; end
    checks++;
    if (wr_n == 4'b1111) begin errors++; $display("FAIL arst_find_strobe: no strobe seen"); en = 1'b0; return; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wr_n !== 4'b1111) begin errors++; $display("FAIL arst_wr_n: got %b required 1111", wr_n); end
    checks++; if (caret !== 1'b1)   begin errors++; $display("FAIL arst_caret: got %b required 1", caret); end
    checks++; if (mem_re !== 1'b0)  begin errors++; $display("FAIL arst_re: got %b required 0", mem_re); end
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    repeat (50) @(negedge clk);
    checks++; if (wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++; $display("FAIL arst_idle: got %0d writes %0d reads required 0", wr_q.size(), rd_q.size());
    end
    en = 1'b1;
    b = 0;
    while (rd_q.size() == 0 && b < 100) begin @(negedge clk); b++; end
    en = 1'b0;
    checks++;
    if (rd_q.size() == 0) begin errors++; $display("FAIL arst_reenable: no read after re-enable"); end
    else if (rd_q[0] !== 4'd0) begin errors++; $display("FAIL arst_restart_addr: got %0d required 0", rd_q[0]); end
  endtask

  task automatic test_onehot();
    checks++;
    if (onehot_bad != 0) begin errors++; $display("FAIL wr_onehot: got %0d multi-low samples required 0", onehot_bad); end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h20;
    test_reset();
    test_full_frame();
    test_filter();
    test_blink();
    test_disable_mid_strobe();
    test_async_reset();
    test_onehot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
